fetch_stage: RTL and testbench

- Instruction fetch stage: owns the program counter and issues sequential fetch requests to the instruction cache.
- Collects each cache response and presents an instruction/PC/error triple to the decode stage through a valid/stall handshake.
- Handles redirects (branch, jump, trap) by flushing outstanding work.
- Sits between the pipeline front-end control and the instruction cache.

---
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time I-cache requests and
// hands instruction/PC/error triples to decode through a valid/stall handshake.
module fetch_stage #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = 32'h00000000,
    parameter logic [DW-1:0] NOP      = 32'h00000013
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic [AW-1:0] i_flush_pc,
    input  logic          i_stall,
    output logic          o_valid,
    output logic [DW-1:0] o_inst,
    output logic [AW-1:0] o_pc,
    output logic [1:0]    o_error,
    output logic          o_ic_en,
    output logic [AW-1:0] o_ic_addr,
    input  logic [DW-1:0] i_ic_data,
    input  logic          i_ic_stall,
    input  logic [1:0]    i_ic_error
);
    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic          r_inflight;
    logic [AW-1:0] r_inflight_pc;
    logic          r_skid_vld;
    logic [DW-1:0] r_skid_inst;
    logic [AW-1:0] r_skid_pc;
    logic [1:0]    r_skid_err;

    logic          w_resp;
    logic          w_resp_err;
    logic [DW-1:0] w_resp_inst;
    logic          w_out_free;
    logic          w_skid_fill;
    logic          w_accept;

    assign w_resp      = r_inflight;
    assign w_resp_err  = r_inflight && (|i_ic_error);
    assign w_resp_inst = w_resp_err ? NOP : i_ic_data;
    assign w_out_free  = !o_valid || !i_stall;
    assign w_skid_fill = w_resp && !w_out_free;

    // A response landing in the skid this cycle, or a faulting response, must
    // block the next request: the skid has one slot and fetch halts on errors.
    assign o_ic_en   = !i_rst && (r_state == S_RUN) && !i_flush && !r_skid_vld
                       && !w_skid_fill && !w_resp_err;
    assign o_ic_addr = r_pc;
    assign w_accept  = o_ic_en && !i_ic_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_skid_vld    <= 1'b0;
            r_skid_inst   <= NOP;
            r_skid_pc     <= '0;
            r_skid_err    <= '0;
            o_valid       <= 1'b0;
            o_inst        <= NOP;
            o_pc          <= '0;
            o_error       <= '0;
        end else if (i_flush) begin
            r_state    <= S_RUN;
            r_pc       <= i_flush_pc;
            r_inflight <= 1'b0;
            r_skid_vld <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            if (w_out_free) begin
                if (r_skid_vld) begin
                    // Skid is older than any response arriving now.
                    o_valid    <= 1'b1;
                    o_inst     <= r_skid_inst;
                    o_pc       <= r_skid_pc;
                    o_error    <= r_skid_err;
                    r_skid_vld <= w_resp;
                    if (w_resp) begin
                        r_skid_inst <= w_resp_inst;
                        r_skid_pc   <= r_inflight_pc;
                        r_skid_err  <= i_ic_error;
                    end
                end else if (w_resp) begin
                    o_valid <= 1'b1;
                    o_inst  <= w_resp_inst;
                    o_pc    <= r_inflight_pc;
                    o_error <= i_ic_error;
                end else begin
                    o_valid <= 1'b0;
                end
            end else if (w_resp) begin
                r_skid_vld  <= 1'b1;
                r_skid_inst <= w_resp_inst;
                r_skid_pc   <= r_inflight_pc;
                r_skid_err  <= i_ic_error;
            end

            if (w_resp_err)
                r_state <= S_HALT;

            r_inflight <= w_accept;
            if (w_accept) begin
                r_pc          <= r_pc + AW'(4);
                r_inflight_pc <= r_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a one-cycle-latency I-cache model pushes expected
// entries on every accepted request; a monitor pops them as decode consumes.
module tb_fetch_stage;
    localparam logic [31:0] NOPI = 32'h00000013;
    localparam logic [31:0] KEY  = 32'hA5A5A5A5;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_flush = 1'b0;
    logic [31:0] i_flush_pc = 32'h0;
    logic        i_stall = 1'b0;
    logic        i_ic_stall = 1'b0;
    logic [31:0] i_ic_data = 32'h0;
    logic [1:0]  i_ic_error = 2'b00;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [1:0]  o_error;
    logic        o_ic_en;
    logic [31:0] o_ic_addr;

    fetch_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_flush_pc(i_flush_pc),
        .i_stall(i_stall), .o_valid(o_valid), .o_inst(o_inst), .o_pc(o_pc),
        .o_error(o_error), .o_ic_en(o_ic_en), .o_ic_addr(o_ic_addr),
        .i_ic_data(i_ic_data), .i_ic_stall(i_ic_stall), .i_ic_error(i_ic_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pc_log[$];
    int          total = 0;
    int          bad = 0;
    logic        fault_en = 1'b0;
    logic [31:0] fault_addr = 32'h14;
    logic [31:0] last_acc = 32'h0;
    logic        c_acc;
    logic [31:0] c_a;
    exp_t        c_e;

    function automatic logic [1:0] err_of(input logic [31:0] a);
        err_of = {fault_en && (a == fault_addr), a[1:0] != 2'b00};
    endfunction

    // Cache model and scoreboard monitor
    always begin
        @(negedge i_clk);
        if (!i_rst && !i_flush && o_valid && !i_stall) begin
            pc_log.push_back(o_pc);
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL deliver_extra: got pc=%h inst=%h, required no output", o_pc, o_inst);
            end else begin
                c_e = sb.pop_front();
                if ({o_pc, o_inst, o_error} !== c_e) begin
                    bad++;
                    $display("FAIL deliver: got pc=%h inst=%h err=%b, required pc=%h inst=%h err=%b",
                             o_pc, o_inst, o_error, c_e.pc, c_e.inst, c_e.err);
                end
            end
        end
        if (i_rst || i_flush) sb.delete();
        c_acc = o_ic_en && !i_ic_stall;
        c_a   = o_ic_addr;
        if (c_acc) begin
            last_acc = c_a;
            c_e.pc   = c_a;
            c_e.err  = err_of(c_a);
            c_e.inst = (c_e.err != 2'b00) ? NOPI : (c_a ^ KEY);
            sb.push_back(c_e);
        end
        @(posedge i_clk);
        #1;
        i_ic_data  = c_acc ? (c_a ^ KEY) : 32'h0;
        i_ic_error = c_acc ? err_of(c_a) : 2'b00;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_flush = 1'b0; i_stall = 1'b0; i_ic_stall = 1'b0;
        tick(); tick();
        i_rst = 1'b0;
    endtask

    task automatic flush_to(input logic [31:0] pc);
        tick();
        i_flush = 1'b1; i_flush_pc = pc;
        tick();
        i_flush = 1'b0;
    endtask

    task automatic test_reset();
        logic        ev;
        logic [31:0] ep;
        i_rst = 1'b1;
        tick(); tick();
        @(negedge i_clk);
        total++;
        if ({o_valid, o_inst, o_pc, o_error, o_ic_en} !== {1'b0, NOPI, 32'h0, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got v=%b inst=%h pc=%h err=%b en=%b, required v=0 inst=%h pc=0 err=00 en=0",
                     o_valid, o_inst, o_pc, o_error, o_ic_en, NOPI);
        end
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            ev = (k >= 2);
            ep = 32'(4 * (k - 2));
            total++;
            if (o_valid !== ev) begin
                bad++;
                $display("FAIL first_valid c%0d: got valid=%b, required %b", k, o_valid, ev);
            end
            if (k >= 2) begin
                total++;
                if (o_pc !== ep || o_inst !== (ep ^ KEY)) begin
                    bad++;
                    $display("FAIL stream c%0d: got pc=%h inst=%h, required pc=%h inst=%h",
                             k, o_pc, o_inst, ep, ep ^ KEY);
                end
            end
        end
    endtask

    task automatic check_log(input string name, input int n, input logic [31:0] base);
        logic [31:0] ep;
        total++;
        if (pc_log.size() != n) begin
            bad++;
            $display("FAIL %s_count: got %0d outputs, required %0d", name, pc_log.size(), n);
        end
        for (int i = 0; i < n && i < pc_log.size(); i++) begin
            ep = base + 32'(4 * i);
            total++;
            if (pc_log[i] !== ep) begin
                bad++;
                $display("FAIL %s_order[%0d]: got pc=%h, required %h", name, i, pc_log[i], ep);
            end
        end
    endtask

    task automatic test_ic_stall();
        do_reset();
        pc_log.delete();
        repeat (4) tick();
        i_ic_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            total++;
            if (o_ic_en !== 1'b1 || o_ic_addr !== 32'h10) begin
                bad++;
                $display("FAIL ic_stall_hold c%0d: got en=%b addr=%h, required en=1 addr=00000010",
                         k, o_ic_en, o_ic_addr);
            end
            tick();
        end
        i_ic_stall = 1'b0;
        repeat (6) tick();
        check_log("ic_stall", 8, 32'h0);
    endtask

    task automatic test_skid();
        do_reset();
        pc_log.delete();
        repeat (3) tick();
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            total++;
            if (o_valid !== 1'b1 || o_pc !== 32'h4 || o_inst !== (32'h4 ^ KEY) || o_ic_en !== 1'b0) begin
                bad++;
                $display("FAIL skid_hold c%0d: got v=%b pc=%h inst=%h en=%b, required v=1 pc=4 inst=%h en=0",
                         k, o_valid, o_pc, o_inst, o_ic_en, 32'h4 ^ KEY);
            end
            tick();
        end
        i_stall = 1'b0;
        repeat (4) tick();
        check_log("skid", 4, 32'h0);
    endtask

    task automatic wait_out(input string name, input logic [31:0] pc,
                            input logic [31:0] inst, input logic [1:0] err);
        logic found = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            @(negedge i_clk);
            if (o_valid) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s_timeout: got no o_valid in 12 cycles, required pc=%h", name, pc);
        end else if (o_pc !== pc || o_inst !== inst || o_error !== err) begin
            bad++;
            $display("FAIL %s: got pc=%h inst=%h err=%b, required pc=%h inst=%h err=%b",
                     name, o_pc, o_inst, o_error, pc, inst, err);
        end
    endtask

    task automatic check_halted(input string name, input logic [31:0] last);
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            total++;
            if (o_ic_en !== 1'b0) begin
                bad++;
                $display("FAIL %s_halt c%0d: got en=%b, required 0", name, k, o_ic_en);
            end
        end
        total++;
        if (last_acc !== last) begin
            bad++;
            $display("FAIL %s_last_req: got %h, required %h", name, last_acc, last);
        end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (4) tick();
        i_flush = 1'b1; i_flush_pc = 32'h200;
        @(negedge i_clk);
        total++;
        if (o_ic_en !== 1'b0) begin
            bad++;
            $display("FAIL flush_en: got en=%b, required 0", o_ic_en);
        end
        tick();
        i_flush = 1'b0;
        wait_out("flush_target", 32'h200, 32'h200 ^ KEY, 2'b00);
    endtask

    task automatic test_fault();
        logic found = 1'b0;
        fault_en = 1'b1; fault_addr = 32'h14;
        do_reset();
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge i_clk);
            if (o_valid && o_pc == 32'h14) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL fault_timeout: got no output for pc 00000014, required one");
        end else if (o_inst !== NOPI || o_error !== 2'b10) begin
            bad++;
            $display("FAIL fault_entry: got inst=%h err=%b, required inst=%h err=10", o_inst, o_error, NOPI);
        end
        check_halted("fault", 32'h14);
        fault_en = 1'b0;
        flush_to(32'h40);
        wait_out("fault_resume", 32'h40, 32'h40 ^ KEY, 2'b00);
    endtask

    task automatic test_misaligned();
        flush_to(32'h102);
        wait_out("misaligned", 32'h102, NOPI, 2'b01);
        check_halted("misaligned", 32'h102);
    endtask

    task automatic test_wrap();
        flush_to(32'hFFFFFFF8);
        pc_log.delete();
        repeat (6) tick();
        check_log("wrap", 4, 32'hFFFFFFF8);
    endtask

    task automatic test_reset_mid_miss();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            total++;
            if (o_valid !== (k == 2) || o_pc !== 32'h0) begin
                bad++;
                $display("FAIL mid_miss c%0d: got v=%b pc=%h, required v=%b pc=00000000",
                         k, o_valid, o_pc, k == 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ic_stall();
        test_skid();
        test_flush();
        test_fault();
        test_misaligned();
        test_wrap();
        test_reset_mid_miss();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required completion");
        $fatal(1);
    end
endmodule
